// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryptor, one round per clock, with the
// round key expanded on the fly alongside the state.
//
// Ports:
//   clk        clock
//   resetn     synchronous, active-low reset
//   in_valid   plaintext/key offer          in_ready   high while IDLE
//   data_in    plaintext (byte 0 at [127:120], column c at [127-32c -:32])
//   key_in     cipher key, same byte order
//   out_valid  high while a ciphertext is held
//   out_ready  downstream accepts ciphertext
//   data_out   registered ciphertext, kept after the handshake
//
// Parameters:
//   CLEAR_ON_DONE  zero key/rcon registers on the output handshake
//   TRACE_EN       simulation-only round trace hook, no hardware effect
module aes_enc_iter #(
  parameter int unsigned CLEAR_ON_DONE = 1,
  parameter int unsigned TRACE_EN      = 0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2040 - {b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of MixColumns.
  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // One forward key-expansion step: previous round key -> next round key.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // SubBytes then ShiftRows: byte (r,c) takes byte (r,(c+r) mod 4); byte
  // index in the vector is r + 4c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
      end
    end
    return o;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t       state_q;
  logic [3:0]   rnd_q;
  logic [127:0] st_q;
  logic [127:0] key_q;
  logic [7:0]   rcon_q;
  logic [127:0] dout_q;

  logic [127:0] rk_d;
  logic [7:0]   rcon_d;
  logic [127:0] sr_d;
  logic [127:0] mc_d;
  logic [127:0] round_d;

  always_comb begin
    rk_d    = key_step(key_q, rcon_q);
    rcon_d  = xtime(rcon_q);
    sr_d    = sub_shift(st_q);
    mc_d    = {mix_word(sr_d[127:96]), mix_word(sr_d[95:64]),
               mix_word(sr_d[63:32]),  mix_word(sr_d[31:0])};
    // Final round skips MixColumns.
    round_d = ((rnd_q == 4'd10) ? sr_d : mc_d) ^ rk_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      key_q   <= '0;
      rcon_q  <= '0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_q    <= data_in ^ key_in;
            key_q   <= key_in;
            rcon_q  <= 8'h01;
            rnd_q   <= 4'd1;
            state_q <= RUN;
          end
        end
        RUN: begin
          st_q   <= round_d;
          key_q  <= rk_d;
          rcon_q <= rcon_d;
          if (rnd_q == 4'd10) begin
            dout_q  <= round_d;
            rnd_q   <= '0;
            state_q <= HOLD;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= IDLE;
            if (CLEAR_ON_DONE != 0) begin
              key_q  <= '0;
              rcon_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign data_out  = dout_q;

  // Round tracing is done by probing st_q/key_q from simulation; nothing is
  // instantiated here so the hardware is identical for either setting.
  if (TRACE_EN != 0) begin : g_trace
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
module tb_aes_enc_iter;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] data_out;

  always #5 clk = ~clk;

  aes_enc_iter #(.CLEAR_ON_DONE(1), .TRACE_EN(0)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    bit           known;
  } job_t;
  job_t sb_q[$];

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference inverse cipher built from a generated S-box; a ciphertext is
  // correct when it decrypts back to the plaintext under the same key.
  function automatic logic [127:0] inv_cipher(input logic [127:0] ct, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] s, x;
    logic [7:0]   a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    s = ct ^ {w[40], w[41], w[42], w[43]};
    for (int r = 9; r >= 0; r--) begin
      x = '0;
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++)
          x[127 - 8*(rr + 4*c) -: 8] = isb[s[127 - 8*(rr + 4*((c + 4 - rr) % 4)) -: 8]];
      s = x ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = s[127 - 32*c -: 32];
          x[127 - 32*c -: 32] = {
            gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09),
            gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d),
            gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b),
            gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e)};
        end
        s = x;
      end
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] ct, input bit known, input bit keep_valid);
    job_t j;
    chk("ready_before_accept", 128'(in_ready), 128'(1));
    data_in  = pt;
    key_in   = key;
    in_valid = 1'b1;
    tick();
    acc_cyc = cyc;
    chk("accepted", 128'(in_ready), 128'(0));
    j.pt = pt; j.key = key; j.ct = ct; j.known = known;
    sb_q.push_back(j);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit perturb, input bit probe);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (perturb) begin
        data_in = rnd128();
        key_in  = rnd128();
      end
      tick();
      lat++;
      if (probe && lat == 1) chk("round_key_1", dut.key_q, B_RK1);
      if (lat == 5) chk("busy_in_ready", 128'(in_ready), 128'(0));
      if (out_valid) got = 1'b1;
    end
    chk("latency", 128'(lat), 128'(10));
    if (probe) chk("round_key_10", dut.key_q, B_RK10);
  endtask

  task automatic drain();
    job_t j;
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_nonempty", 128'(0), 128'(1));
    end else begin
      j = sb_q.pop_front();
      chk("out_valid_at_pop", 128'(out_valid), 128'(1));
      if (j.known) begin
        chk("ciphertext", data_out, j.ct);
        chk("known_loopback", inv_cipher(data_out, j.key), j.pt);
      end else begin
        chk("loopback", inv_cipher(data_out, j.key), j.pt);
      end
    end
    tick();
    chk("out_valid_after_hs", 128'(out_valid), 128'(0));
    chk("in_ready_after_hs", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] snap;
    int unsigned  a1;

    for (int i = 0; i < 256; i++) begin
      logic [7:0] x, inv, s;
      x = 8'(i);
      inv = '0;
      if (x != 8'h00)
        for (int k = 1; k < 256; k++)
          if (gm(x, 8'(k)) == 8'h01) inv = 8'(k);
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sb[i]  = s;
      isb[s] = x;
    end

    // Reset state
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_data_out", data_out, 128'(0));
    chk("rst_key", dut.key_q, 128'(0));
    chk("rst_rcon", 128'(dut.rcon_q), 128'(0));

    // FIPS-197 C.1 with out_ready held high
    out_ready = 1'b1;
    start_job(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b0);
    wait_out(1'b0, 1'b0);
    drain();

    // App. B with round-key probes and 20 cycles of backpressure
    out_ready = 1'b0;
    start_job(B_PT, B_KEY, B_CT, 1'b1, 1'b0);
    wait_out(1'b0, 1'b1);
    snap = data_out;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_data_stable", data_out, snap);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    drain();
    chk("key_cleared", dut.key_q, 128'(0));
    chk("rcon_cleared", 128'(dut.rcon_q), 128'(0));
    chk("data_out_kept", data_out, B_CT);

    // Inputs churning during RUN, back-to-back jobs at peak rate
    out_ready = 1'b1;
    start_job(B_PT, B_KEY, B_CT, 1'b1, 1'b1);
    a1 = acc_cyc;
    wait_out(1'b1, 1'b0);
    drain();
    start_job(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b1);
    chk("accept_period", 128'(acc_cyc - a1), 128'(12));
    wait_out(1'b1, 1'b0);
    in_valid = 1'b0;
    drain();

    // Reset at round 5 aborts the job
    start_job(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rnd", 128'(dut.rnd_q), 128'(5));
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    sb_q.delete();
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_data_out", data_out, 128'(0));
    start_job(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b0);
    wait_out(1'b0, 1'b0);
    drain();

    // Random loopback
    for (int n = 0; n < 100; n++) begin
      start_job(rnd128(), rnd128(), '0, 1'b0, 1'b0);
      wait_out(1'b0, 1'b0);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
